// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line-buffer sequencer: state encoding,
// default erase length and statistics counter width.
package sprite_pkg;

  localparam logic [2:0] ST_INIT_A     = 3'd0;
  localparam logic [2:0] ST_INIT_B     = 3'd1;
  localparam logic [2:0] ST_IDLE       = 3'd2;
  localparam logic [2:0] ST_WAIT_ERASE = 3'd3;
  localparam logic [2:0] ST_RENDER     = 3'd4;

  localparam int ERASE_CYCLES_DEFAULT = 160;
  localparam int STAT_W               = 8;

endpackage

// File: rtl/sprite_erase_timer.sv
// Tracks an erase running in the line buffer: busy from the load cycle through
// counter expiry, with a done strobe on the last busy cycle.
module sprite_erase_timer
  import sprite_pkg::*;
#(
  parameter int ERASE_CYCLES = ERASE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic busy_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(ERASE_CYCLES + 2);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ERASE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    if (load_i) begin
      cnt_d  = LOAD_VAL;
      busy_d = 1'b1;
    end else begin
      busy_d = busy_q && (cnt_q != '0);
      cnt_d  = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  // Last busy cycle; lets the sequencer act so its effect lands as busy drops.
  assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/sprite_linebuf_ctrl.sv
// Double-buffered sprite line buffer sequencer: init erases, per-line buffer
// swap, renderer start/abort and saturating timing-violation statistics.
module sprite_linebuf_ctrl
  import sprite_pkg::*;
#(
  parameter int ERASE_CYCLES = ERASE_CYCLES_DEFAULT,
  parameter int LINE_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              line_start,
  input  logic [LINE_W-1:0] line_idx,
  input  logic              composer_line_end,
  input  logic              render_done,
  output logic              render_start,
  output logic [LINE_W-1:0] render_line,
  output logic              render_abort,
  output logic              active_render_buffer,
  output logic              composer_erase_start,
  output logic              erase_busy,
  output logic              ready,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] overrun_cnt,
  output logic [STAT_W-1:0] late_cnt
);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]        state_q, state_d;
  logic              act_q, act_d;
  logic              erased_q, erased_d;
  logic              rstart_q, rstart_d;
  logic              abort_q, abort_d;
  logic              estart_q, estart_d;
  logic              ready_q, ready_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic [LINE_W-1:0] pend_q, pend_d;
  logic [STAT_W-1:0] ovr_q, ovr_d;
  logic [STAT_W-1:0] late_q, late_d;
  logic              erase_done;
  logic              init, live, accept_ls, swap, ovr_inc, late_inc;
  logic [LINE_W-1:0] swap_line;

  sprite_erase_timer #(.ERASE_CYCLES(ERASE_CYCLES)) u_erase_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (estart_d),
    .busy_o (erase_busy),
    .done_o (erase_done)
  );

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    erased_d  = erased_q;
    rstart_d  = 1'b0;
    abort_d   = 1'b0;
    estart_d  = 1'b0;
    ready_d   = ready_q;
    rline_d   = rline_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    late_d    = late_q;
    swap      = 1'b0;
    swap_line = pend_q;
    ovr_inc   = 1'b0;
    late_inc  = 1'b0;
    init      = (state_q == ST_INIT_A) || (state_q == ST_INIT_B);
    live      = (state_q == ST_RENDER) && !render_done;
    accept_ls = line_start && enable;

    case (state_q)
      ST_INIT_A: begin
        if (!erase_busy) begin
          estart_d = 1'b1;
        end else if (erase_done) begin
          // Second erase is chained onto the first so the two run back to back.
          act_d    = ~act_q;
          estart_d = 1'b1;
          state_d  = ST_INIT_B;
        end
      end
      ST_INIT_B: begin
        if (erase_done) begin
          act_d   = ~act_q;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE, ST_RENDER: begin
        if (accept_ls) begin
          pend_d = line_idx;
          if (live) begin
            abort_d = 1'b1;
            ovr_inc = 1'b1;
          end
          if (erased_q && !erase_busy) begin
            // An abort takes this cycle's pulse slot, so the start slips one cycle.
            if (live) begin
              state_d = ST_WAIT_ERASE;
            end else begin
              swap      = 1'b1;
              swap_line = line_idx;
              state_d   = ST_RENDER;
            end
          end else begin
            estart_d = !erase_busy;
            late_inc = 1'b1;
            state_d  = ST_WAIT_ERASE;
          end
        end else begin
          if (state_q == ST_RENDER) begin
            if (render_done) begin
              state_d = ST_IDLE;
            end else if (!enable) begin
              abort_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
          if (composer_line_end && !erased_q && !erase_busy) estart_d = 1'b1;
        end
      end
      ST_WAIT_ERASE: begin
        if (erase_done || !erase_busy) begin
          swap    = 1'b1;
          state_d = ST_RENDER;
        end
      end
      default: state_d = ST_INIT_A;
    endcase

    if (erase_done && !init) erased_d = 1'b1;
    if (swap) begin
      act_d    = ~act_q;
      erased_d = 1'b0;
      rline_d  = swap_line;
      rstart_d = 1'b1;
    end

    if (!init && stat_clr) begin
      ovr_d  = '0;
      late_d = '0;
    end else begin
      if (ovr_inc)  ovr_d  = sat_inc(ovr_q);
      if (late_inc) late_d = sat_inc(late_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT_A;
      act_q    <= 1'b0;
      erased_q <= 1'b0;
      rstart_q <= 1'b0;
      abort_q  <= 1'b0;
      estart_q <= 1'b0;
      ready_q  <= 1'b0;
      rline_q  <= '0;
      ovr_q    <= '0;
      late_q   <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      erased_q <= erased_d;
      rstart_q <= rstart_d;
      abort_q  <= abort_d;
      estart_q <= estart_d;
      ready_q  <= ready_d;
      rline_q  <= rline_d;
      ovr_q    <= ovr_d;
      late_q   <= late_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign render_start         = rstart_q;
  assign render_line          = rline_q;
  assign render_abort         = abort_q;
  assign active_render_buffer = act_q;
  assign composer_erase_start = estart_q;
  assign ready                = ready_q;
  assign overrun_cnt          = ovr_q;
  assign late_cnt             = late_q;

endmodule

// File: tb/tb_sprite_linebuf_ctrl.sv
// Directed bench for sprite_linebuf_ctrl with ERASE_CYCLES=160 and hand-computed
// cycle positions for every pulse.
module tb_sprite_linebuf_ctrl;

  localparam int E  = 160;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          line_start = 1'b0;
  logic [LW-1:0] line_idx = '0;
  logic          composer_line_end = 1'b0;
  logic          render_done = 1'b0;
  logic          stat_clr = 1'b0;
  logic          render_start, render_abort, active_render_buffer;
  logic          composer_erase_start, erase_busy, ready;
  logic [LW-1:0] render_line;
  logic [7:0]    overrun_cnt, late_cnt;

  int n_chk = 0;
  int n_err = 0;
  int first_es = -1;
  int second_es = -1;
  int n_es = 0;
  int ready_cyc = -1;
  int mid_act = -1;
  int seen;

  sprite_linebuf_ctrl #(.ERASE_CYCLES(E), .LINE_W(LW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .line_start           (line_start),
    .line_idx             (line_idx),
    .composer_line_end    (composer_line_end),
    .render_done          (render_done),
    .render_start         (render_start),
    .render_line          (render_line),
    .render_abort         (render_abort),
    .active_render_buffer (active_render_buffer),
    .composer_erase_start (composer_erase_start),
    .erase_busy           (erase_busy),
    .ready                (ready),
    .stat_clr             (stat_clr),
    .overrun_cnt          (overrun_cnt),
    .late_cnt             (late_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ls(input logic [LW-1:0] idx);
    line_start = 1'b1;
    line_idx   = idx;
    tick();
    line_start = 1'b0;
  endtask

  task automatic cle();
    composer_line_end = 1'b1;
    tick();
    composer_line_end = 1'b0;
  endtask

  task automatic rdone();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    enable = 1'b1;
    repeat (3) tick();
    chk("rst_act",   32'(active_render_buffer), 32'd0);
    chk("rst_ready", 32'(ready),                32'd0);
    chk("rst_busy",  32'(erase_busy),           32'd0);
    chk("rst_es",    32'(composer_erase_start), 32'd0);
    chk("rst_rs",    32'(render_start),         32'd0);
    chk("rst_line",  32'(render_line),          32'd0);
    chk("rst_ovr",   32'(overrun_cnt),          32'd0);

    // Init: erase pulses at cycles 1 and 163, ready at 325.
    rst = 1'b0;
    for (int c = 1; c <= 400 && ready_cyc < 0; c++) begin
      tick();
      if (composer_erase_start) begin
        if (n_es == 0) first_es = c;
        else if (n_es == 1) begin
          second_es = c;
          mid_act   = int'(active_render_buffer);
        end
        n_es++;
      end
      if (ready) ready_cyc = c;
    end
    chk("init_first_es",  first_es,  32'd1);
    chk("init_second_es", second_es, 32'd163);
    chk("init_n_es",      n_es,      32'd2);
    chk("init_mid_act",   mid_act,   32'd1);
    chk("init_ready_cyc", ready_cyc, 32'd325);
    chk("init_act",  32'(active_render_buffer), 32'd0);
    chk("init_late", 32'(late_cnt), 32'd0);

    // Normal line: idle, clean buffer by line_start.
    cle();
    chk("norm_es",   32'(composer_erase_start), 32'd1);
    chk("norm_busy", 32'(erase_busy),           32'd1);
    repeat (199) tick();
    chk("norm_busy_end", 32'(erase_busy), 32'd0);
    ls(10'd37);
    chk("norm_rs",    32'(render_start),         32'd1);
    chk("norm_act",   32'(active_render_buffer), 32'd1);
    chk("norm_line",  32'(render_line),          32'd37);
    chk("norm_abort", 32'(render_abort),         32'd0);
    tick();
    chk("norm_rs_off", 32'(render_start), 32'd0);
    rdone();
    chk("norm_ovr",  32'(overrun_cnt), 32'd0);
    chk("norm_late", 32'(late_cnt),    32'd0);

    // Missing line_end: forced erase at T+1, swap at T+E+3.
    ls(10'd5);
    chk("miss_es",    32'(composer_erase_start), 32'd1);
    chk("miss_late",  32'(late_cnt),             32'd1);
    chk("miss_abort", 32'(render_abort),         32'd0);
    chk("miss_act0",  32'(active_render_buffer), 32'd1);
    repeat (E + 1) tick();
    chk("miss_busy_last", 32'(erase_busy),   32'd1);
    chk("miss_rs_early",  32'(render_start), 32'd0);
    tick();
    chk("miss_rs",   32'(render_start),         32'd1);
    chk("miss_act",  32'(active_render_buffer), 32'd0);
    chk("miss_line", 32'(render_line),          32'd5);
    chk("miss_busy", 32'(erase_busy),           32'd0);

    // Overrun with forced erase.
    ls(10'd6);
    chk("ovr_abort", 32'(render_abort),         32'd1);
    chk("ovr_cnt",   32'(overrun_cnt),          32'd1);
    chk("ovr_es",    32'(composer_erase_start), 32'd1);
    chk("ovr_late",  32'(late_cnt),             32'd2);
    chk("ovr_rs0",   32'(render_start),         32'd0);
    tick();
    chk("ovr_abort_off", 32'(render_abort), 32'd0);
    repeat (E + 1) tick();
    chk("ovr_rs",   32'(render_start),         32'd1);
    chk("ovr_line", 32'(render_line),          32'd6);
    chk("ovr_act",  32'(active_render_buffer), 32'd1);

    // Overrun with a clean buffer: abort first, start one cycle later.
    cle();
    chk("ovf_es", 32'(composer_erase_start), 32'd1);
    repeat (E + 2) tick();
    chk("ovf_busy", 32'(erase_busy), 32'd0);
    ls(10'd7);
    chk("ovf_abort", 32'(render_abort), 32'd1);
    chk("ovf_rs0",   32'(render_start), 32'd0);
    chk("ovf_cnt",   32'(overrun_cnt),  32'd2);
    chk("ovf_late",  32'(late_cnt),     32'd2);
    tick();
    chk("ovf_rs",     32'(render_start),         32'd1);
    chk("ovf_abort1", 32'(render_abort),         32'd0);
    chk("ovf_line",   32'(render_line),          32'd7);
    chk("ovf_act",    32'(active_render_buffer), 32'd0);

    // stat_clr beats same-cycle increments.
    stat_clr = 1'b1;
    ls(10'd8);
    stat_clr = 1'b0;
    chk("clr_ovr",   32'(overrun_cnt),  32'd0);
    chk("clr_late",  32'(late_cnt),     32'd0);
    chk("clr_abort", 32'(render_abort), 32'd1);
    repeat (E + 2) tick();
    chk("clr_rs",  32'(render_start),         32'd1);
    chk("clr_act", 32'(active_render_buffer), 32'd1);

    // Late erase: line_start 10 cycles after line_end.
    rdone();
    cle();
    chk("late_es", 32'(composer_erase_start), 32'd1);
    repeat (9) tick();
    ls(10'd11);
    chk("late_cnt",   32'(late_cnt),             32'd1);
    chk("late_es2",   32'(composer_erase_start), 32'd0);
    chk("late_rs0",   32'(render_start),         32'd0);
    chk("late_abort", 32'(render_abort),         32'd0);
    repeat (151) tick();
    chk("late_rs_early", 32'(render_start), 32'd0);
    tick();
    chk("late_rs",   32'(render_start),         32'd1);
    chk("late_line", 32'(render_line),          32'd11);
    chk("late_act",  32'(active_render_buffer), 32'd0);

    // line_start with render_done: no abort, no overrun.
    render_done = 1'b1;
    ls(10'd12);
    render_done = 1'b0;
    chk("both_abort", 32'(render_abort),         32'd0);
    chk("both_ovr",   32'(overrun_cnt),          32'd0);
    chk("both_es",    32'(composer_erase_start), 32'd1);
    chk("both_late",  32'(late_cnt),             32'd2);
    repeat (E + 2) tick();
    chk("both_rs",  32'(render_start),         32'd1);
    chk("both_act", 32'(active_render_buffer), 32'd1);

    // enable low while rendering.
    enable = 1'b0;
    tick();
    chk("en_abort", 32'(render_abort), 32'd1);
    tick();
    chk("en_abort_off", 32'(render_abort), 32'd0);
    ls(10'd13);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (render_start || composer_erase_start || render_abort) seen++;
      tick();
    end
    chk("en_ignored", seen, 32'd0);
    chk("en_act",     32'(active_render_buffer), 32'd1);
    chk("en_late",    32'(late_cnt), 32'd2);
    enable = 1'b1;
    ls(10'd14);
    chk("en_es",   32'(composer_erase_start), 32'd1);
    chk("en_late2", 32'(late_cnt),            32'd3);
    repeat (E + 2) tick();
    chk("en_rs",   32'(render_start),         32'd1);
    chk("en_line", 32'(render_line),          32'd14);
    chk("en_act2", 32'(active_render_buffer), 32'd0);

    // Saturation: 257 overruns from RENDER.
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("sat_clr", 32'(overrun_cnt), 32'd0);
    for (int i = 0; i < 257; i++) begin
      ls(LW'(i));
      if (i == 0) chk("sat_first", 32'(overrun_cnt), 32'd1);
      repeat (E + 2) tick();
    end
    chk("sat_ovr",  32'(overrun_cnt),          32'd255);
    chk("sat_late", 32'(late_cnt),             32'd255);
    chk("sat_rs",   32'(render_start),         32'd1);
    chk("sat_act",  32'(active_render_buffer), 32'd1);

    // Asynchronous reset mid-operation.
    rst = 1'b1;
    #1;
    chk("mrst_act",   32'(active_render_buffer), 32'd0);
    chk("mrst_ready", 32'(ready),                32'd0);
    chk("mrst_ovr",   32'(overrun_cnt),          32'd0);
    chk("mrst_late",  32'(late_cnt),             32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
